// File: rtl/iob_mul_shiftadd_pkg.sv
// Shared types for the shift-add multiplier.
// FSM encoding and counter sizing helper.
package iob_mul_shiftadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;

    // Counter must be able to hold the value DATA_W itself.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/iob_mul_shiftadd_step.sv
// One shift-add iteration: conditional add of mcand into the
// upper half, then shift the {acc_hi, shift_reg} pair right by one.
module iob_mul_shiftadd_step
    import iob_mul_shiftadd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W:0]   acc_hi,
    input  logic [DATA_W-1:0] shift_reg,
    input  logic [DATA_W-1:0] mcand,
    output logic [DATA_W:0]   acc_hi_nx,
    output logic [DATA_W-1:0] shift_reg_nx
);

    logic [DATA_W:0] addend;
    logic [DATA_W:0] sum;

    always_comb begin
        addend = shift_reg[0] ? {1'b0, mcand} : '0;
        sum    = acc_hi + addend;
        acc_hi_nx    = {1'b0, sum[DATA_W:1]};
        shift_reg_nx = {sum[0], shift_reg[DATA_W-1:1]};
    end

endmodule

// File: rtl/iob_mul_shiftadd.sv
// Sequential unsigned shift-add multiplier, one multiplier bit
// per cycle, start/done handshake shared with the divider family.
module iob_mul_shiftadd
    import iob_mul_shiftadd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     multiplicand_i,
    input  logic [DATA_W-1:0]     multiplier_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     mcand_q, mcand_d;
    logic [DATA_W-1:0]     sreg_q, sreg_d;
    logic [DATA_W:0]       acc_q, acc_d;
    logic [2*DATA_W-1:0]   prod_q, prod_d;
    logic                  done_q, done_d;

    logic [DATA_W:0]       acc_nx;
    logic [DATA_W-1:0]     sreg_nx;

    iob_mul_shiftadd_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .acc_hi       (acc_q),
        .shift_reg    (sreg_q),
        .mcand        (mcand_q),
        .acc_hi_nx    (acc_nx),
        .shift_reg_nx (sreg_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    mcand_d = multiplicand_i;
                    sreg_d  = multiplier_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d  = acc_nx;
                sreg_d = sreg_nx;
                cnt_d  = cnt_q + CNT_W'(1);
                // Last iteration: publish the product only now.
                if (cnt_q == LAST) begin
                    prod_d  = {acc_nx[DATA_W-1:0], sreg_nx};
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            sreg_q  <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign done_o    = done_q;
    assign product_o = prod_q;

endmodule
